// File: rtl/tt_monitor_pkg.sv
// Shared types and constants for the truth-table monitor: FSM state encoding,
// golden 2-input truth tables (bit index {a,b}) and the saturating count helper.
package tt_monitor_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FCNT_W = 8;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef logic [1:0] vec_t;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/truth_table_monitor_if.sv
// Stimulus/result bundle between a monitor and whoever drives the gate under test.
interface truth_table_monitor_if;

    logic       enable;
    logic       clear;
    logic       a;
    logic       b;
    logic       y;
    logic [3:0] coverage;
    logic       done;
    logic       fail;
    logic [1:0] fail_index;
    logic [7:0] fail_count;
    logic       pass;

    modport master (
        output enable, clear, a, b, y,
        input  coverage, done, fail, fail_index, fail_count, pass
    );

    modport slave (
        input  enable, clear, a, b, y,
        output coverage, done, fail, fail_index, fail_count, pass
    );

endinterface

// File: rtl/truth_table_monitor_settle_counter.sv
// Down-counter that gives the gate output time to settle; stops at zero.
module settle_counter
    import tt_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_monitor.sv
// Checks a 2-input gate against a golden truth table, one settled vector at a
// time, accumulating coverage and sticky failure information.
module truth_table_monitor
    import tt_monitor_pkg::*;
#(
    parameter logic [3:0]  EXPECTED      = TT_XOR,
    parameter int unsigned SETTLE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t            state_q;
    state_t            state_d;
    vec_t              ab_q;
    vec_t              ab_now;
    logic              latch;
    logic              cnt_load;
    logic              cnt_zero;
    logic              check_en;
    logic [3:0]        coverage_q;
    logic              fail_q;
    vec_t              fail_index_q;
    logic [FCNT_W-1:0] fail_count_q;

    assign ab_now = {mon.a, mon.b};

    settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (SETTLE_LOAD),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clear outranks enable, and both outrank the compare, so a CHECK
    // coinciding with either records nothing.
    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        cnt_load = 1'b0;
        check_en = 1'b0;
        if (mon.clear || !mon.enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    latch    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    if (ab_now != ab_q) begin
                        latch    = 1'b1;
                        cnt_load = 1'b1;
                    end else if (cnt_zero) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    check_en = 1'b1;
                    state_d  = HOLD;
                end
                HOLD: begin
                    if (ab_now != ab_q) begin
                        latch    = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ab_q <= '0;
        end else if (latch) begin
            ab_q <= ab_now;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mon.clear) begin
            coverage_q   <= '0;
            fail_q       <= 1'b0;
            fail_index_q <= '0;
            fail_count_q <= '0;
        end else if (check_en) begin
            coverage_q[ab_q] <= 1'b1;
            if (mon.y != EXPECTED[ab_q]) begin
                fail_q       <= 1'b1;
                fail_count_q <= sat_inc(fail_count_q);
                if (!fail_q) begin
                    fail_index_q <= ab_q;
                end
            end
        end
    end

    assign mon.coverage   = coverage_q;
    assign mon.done       = &coverage_q;
    assign mon.fail       = fail_q;
    assign mon.fail_index = fail_index_q;
    assign mon.fail_count = fail_count_q;
    assign mon.pass       = (&coverage_q) & ~fail_q;

endmodule
